// File: rtl/serial_rx_frame_if.sv
// Parallel-side and bit-stream signals of the framed serial receiver.
// The slave modport is the receiver; the master modport is the driving/consuming side.
interface serial_rx_frame_if #(
  parameter int DATA_W = 8
);
  logic              si;
  logic              en;
  logic              dready;
  logic [DATA_W-1:0] dout;
  logic              dvalid;
  logic              perr;
  logic              ferr;
  logic              ovr;

  modport master (
    output si, en, dready,
    input  dout, dvalid, perr, ferr, ovr
  );

  modport slave (
    input  si, en, dready,
    output dout, dvalid, perr, ferr, ovr
  );
endinterface

// File: rtl/serial_rx_frame.sv
// Framed serial receiver: start, DATA_W bits LSB-first, optional parity, stop.
// Bits are taken only on strobe cycles; the word is presented on a valid/ready handshake.
module serial_rx_frame #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input logic               i_ck,
  input logic               i_rst,
  serial_rx_frame_if.slave  bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_PAR  = 3'd2,
    S_STOP = 3'd3,
    S_BRK  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic              r_par;
  logic              w_par_nxt;
  logic              w_frame_done;
  logic              w_ferr_set;
  logic              w_perr;

  logic [DATA_W-1:0] r_dout;
  logic              r_dvalid;
  logic              r_perr;
  logic              r_ferr;
  logic              r_ovr;

  // Next-state and datapath decode; nothing moves unless the bit strobe is high
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_par_nxt    = r_par;
    w_frame_done = 1'b0;
    w_ferr_set   = 1'b0;
    if (bus.en) begin
      case (r_state)
        S_IDLE: begin
          if (!bus.si) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_DATA: begin
          w_shift_nxt             = r_shift >> 1;
          w_shift_nxt[DATA_W-1]   = bus.si;
          w_cnt_nxt               = r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = (PARITY_EN != 0) ? S_PAR : S_STOP;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
        S_PAR: begin
          w_par_nxt   = bus.si;
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          if (bus.si) begin
            w_frame_done = 1'b1;
            w_state_nxt  = S_IDLE;
          end else begin
            w_ferr_set  = 1'b1;
            w_state_nxt = S_BRK;
          end
        end
        S_BRK: begin
          // A low line here is still the break, never a new start bit
          if (bus.si) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_BRK;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  assign w_perr = (PARITY_EN != 0) ? (^r_shift ^ r_par ^ (PARITY_ODD != 0)) : 1'b0;

  // Receive FSM state, bit counter and shift register
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
    end
  end

  // Output word, handshake and error pulses; a full holding register drops the new frame
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_ferr <= w_ferr_set;
      r_ovr  <= 1'b0;
      if (w_frame_done) begin
        if (!r_dvalid || bus.dready) begin
          r_dout   <= r_shift;
          r_dvalid <= 1'b1;
          r_perr   <= w_perr;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_dvalid && bus.dready) begin
        r_dvalid <= 1'b0;
      end else begin
        r_dvalid <= r_dvalid;
      end
    end
  end

  assign bus.dout   = r_dout;
  assign bus.dvalid = r_dvalid;
  assign bus.perr   = r_perr;
  assign bus.ferr   = r_ferr;
  assign bus.ovr    = r_ovr;

endmodule

// File: tb/tb_serial_rx_frame.sv
// Directed bench for serial_rx_frame: an even-parity and an odd-parity receiver
// share one stimulus stream; expected values are hand-computed per step.
module tb_serial_rx_frame;

  logic clk;
  logic rst;
  logic si;
  logic en;
  logic dready;
  int   n_checks;
  int   n_errors;
  int   ferr_pulses;
  int   ovr_pulses;

  serial_rx_frame_if #(.DATA_W(8)) u_if_e ();
  serial_rx_frame_if #(.DATA_W(8)) u_if_o ();

  assign u_if_e.si     = si;
  assign u_if_e.en     = en;
  assign u_if_e.dready = dready;
  assign u_if_o.si     = si;
  assign u_if_o.en     = en;
  assign u_if_o.dready = dready;

  serial_rx_frame #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_even (
    .i_ck  (clk),
    .i_rst (rst),
    .bus   (u_if_e)
  );

  serial_rx_frame #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1)) u_dut_odd (
    .i_ck  (clk),
    .i_rst (rst),
    .bus   (u_if_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count error pulses of the even receiver, sampled mid-cycle
  always @(negedge clk) begin
    if (u_if_e.ferr === 1'b1) ferr_pulses++;
    if (u_if_e.ovr === 1'b1) ovr_pulses++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit period: strobe for one cycle, then three idle cycles
  task automatic send_bit(input logic b);
    si = b;
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic send_body(input logic [7:0] d, input logic p);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
  endtask

  // Stop-bit strobe only; caller checks the outputs right after it
  task automatic stop_strobe(input logic b);
    si = b;
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    ferr_pulses = 0;
    ovr_pulses  = 0;
    si     = 1'b0;
    en     = 1'b1;
    dready = 1'b0;
    rst    = 1'b1;

    // T1 reset
    tick();
    tick();
    chk("rst_dout",   16'(u_if_e.dout), 16'h0000);
    chk("rst_dvalid", 16'(u_if_e.dvalid), 16'h0000);
    chk("rst_perr",   16'(u_if_e.perr), 16'h0000);
    chk("rst_ferr",   16'(u_if_e.ferr), 16'h0000);
    chk("rst_ovr",    16'(u_if_e.ovr), 16'h0000);
    rst = 1'b0;
    si  = 1'b1;
    tick();
    tick();
    tick();
    chk("idle_dvalid", 16'(u_if_e.dvalid), 16'h0000);
    en = 1'b0;
    tick();

    // T2 good frame
    send_body(8'hA5, 1'b0);
    chk("t2_pre_dvalid", 16'(u_if_e.dvalid), 16'h0000);
    stop_strobe(1'b1);
    chk("t2_dvalid", 16'(u_if_e.dvalid), 16'h0001);
    chk("t2_dout",   16'(u_if_e.dout), 16'h00A5);
    chk("t2_perr",   16'(u_if_e.perr), 16'h0000);
    dready = 1'b1;
    tick();
    dready = 1'b0;
    chk("t2_accept_dvalid", 16'(u_if_e.dvalid), 16'h0000);
    chk("t2_hold_dout",     16'(u_if_e.dout), 16'h00A5);
    tick();

    // T3 parity error, even vs odd
    send_body(8'h01, 1'b0);
    stop_strobe(1'b1);
    chk("t3_dvalid",    16'(u_if_e.dvalid), 16'h0001);
    chk("t3_dout",      16'(u_if_e.dout), 16'h0001);
    chk("t3_perr_even", 16'(u_if_e.perr), 16'h0001);
    chk("t3_dout_odd",  16'(u_if_o.dout), 16'h0001);
    chk("t3_perr_odd",  16'(u_if_o.perr), 16'h0000);
    dready = 1'b1;
    tick();
    dready = 1'b0;
    chk("t3_accept_dvalid", 16'(u_if_e.dvalid), 16'h0000);

    // T4 framing error, break, then recovery
    send_body(8'h3C, 1'b0);
    stop_strobe(1'b0);
    chk("t4_ferr",   16'(u_if_e.ferr), 16'h0001);
    chk("t4_dvalid", 16'(u_if_e.dvalid), 16'h0000);
    chk("t4_ovr",    16'(u_if_e.ovr), 16'h0000);
    tick();
    chk("t4_ferr_clear", 16'(u_if_e.ferr), 16'h0000);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_body(8'h55, 1'b0);
    stop_strobe(1'b1);
    chk("t4_dvalid_55", 16'(u_if_e.dvalid), 16'h0001);
    chk("t4_dout_55",   16'(u_if_e.dout), 16'h0055);
    chk("t4_perr_55",   16'(u_if_e.perr), 16'h0000);
    dready = 1'b1;
    tick();
    dready = 1'b0;

    // T5 overrun, then back-to-back with accept on completion
    send_body(8'h11, 1'b0);
    stop_strobe(1'b1);
    chk("t5_dout_11", 16'(u_if_e.dout), 16'h0011);
    send_body(8'h22, 1'b0);
    stop_strobe(1'b1);
    chk("t5_ovr",        16'(u_if_e.ovr), 16'h0001);
    chk("t5_dout_kept",  16'(u_if_e.dout), 16'h0011);
    chk("t5_dvalid_ovr", 16'(u_if_e.dvalid), 16'h0001);
    tick();
    chk("t5_ovr_clear", 16'(u_if_e.ovr), 16'h0000);
    send_body(8'h22, 1'b0);
    dready = 1'b1;
    stop_strobe(1'b1);
    dready = 1'b0;
    chk("t5_dout_22",   16'(u_if_e.dout), 16'h0022);
    chk("t5_dvalid_22", 16'(u_if_e.dvalid), 16'h0001);
    chk("t5_no_ovr",    16'(u_if_e.ovr), 16'h0000);
    dready = 1'b1;
    tick();
    dready = 1'b0;
    chk("t5_accept_dvalid", 16'(u_if_e.dvalid), 16'h0000);

    // T6 reset mid-frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    si  = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("t6_dvalid_rst", 16'(u_if_e.dvalid), 16'h0000);
    send_body(8'hF0, 1'b0);
    stop_strobe(1'b1);
    chk("t6_dout",   16'(u_if_e.dout), 16'h00F0);
    chk("t6_dvalid", 16'(u_if_e.dvalid), 16'h0001);
    chk("t6_perr",   16'(u_if_e.perr), 16'h0000);
    tick();
    tick();
    chk("ferr_pulse_count", 16'(ferr_pulses), 16'd1);
    chk("ovr_pulse_count",  16'(ovr_pulses), 16'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
